res_argmax: RTL and testbench

//  Classifier head: sits directly downstream of the 10-lane result accumulator.

---
 rtl/res_argmax.sv | 122 ++++++++++++
 tb/tb_res_argmax.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/res_argmax.sv
// Serial argmax classifier head: buffers one score vector, scans one lane per cycle, returns winner.
// Define ARGMAX_SIGNED_EN to compare scores as two's-complement; default build compares unsigned.
module res_argmax #(
    parameter int N_CLS  = 10,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pre_valid,
    output logic              o_pre_ready,
    input  logic [DATA_W-1:0] i_res [N_CLS-1:0],
    output logic              o_post_valid,
    input  logic              i_post_ready,
    output logic [IDX_W-1:0]  o_idx,
    output logic [DATA_W-1:0] o_max
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [DATA_W-1:0] lane_buf_r [N_CLS-1:0];
    logic [IDX_W-1:0]  cnt_r;
    logic [IDX_W-1:0]  best_idx_r;
    logic [DATA_W-1:0] best_val_r;
    logic [DATA_W-1:0] cand_s;
    logic [IDX_W-1:0]  nxt_idx_s;
    logic [DATA_W-1:0] nxt_val_s;
    logic              better_s;
    logic              last_s;
    logic              pre_fire_s;
    logic              post_fire_s;

    assign pre_fire_s  = i_pre_valid & o_pre_ready;
    assign post_fire_s = o_post_valid & i_post_ready;
    assign cand_s      = lane_buf_r[cnt_r];
    assign last_s      = (cnt_r == IDX_W'(N_CLS - 1));

    // Strict compare of the current lane against the running best, so ties keep the lower index.
    always_comb begin
        better_s  = 1'b0;
        nxt_idx_s = best_idx_r;
        nxt_val_s = best_val_r;
`ifdef ARGMAX_SIGNED_EN
        better_s = ($signed(cand_s) > $signed(best_val_r));
`else
        better_s = (cand_s > best_val_r);
`endif
        if (better_s) begin
            nxt_idx_s = cnt_r;
            nxt_val_s = cand_s;
        end else begin
            nxt_idx_s = best_idx_r;
            nxt_val_s = best_val_r;
        end
    end

    // Private copy of the score vector, so upstream is released on the accept cycle.
    always_ff @(posedge i_clk) begin
        if (pre_fire_s && !i_rst) begin
            lane_buf_r <= i_res;
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= IDLE;
            o_pre_ready  <= 1'b1;
            o_post_valid <= 1'b0;
            o_idx        <= {IDX_W{1'b0}};
            o_max        <= {DATA_W{1'b0}};
            cnt_r        <= {IDX_W{1'b0}};
            best_idx_r   <= {IDX_W{1'b0}};
            best_val_r   <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (pre_fire_s) begin
                        best_val_r  <= i_res[0];
                        best_idx_r  <= {IDX_W{1'b0}};
                        cnt_r       <= IDX_W'(1);
                        o_pre_ready <= 1'b0;
                        state_r     <= SCAN;
                    end
                end
                SCAN: begin
                    best_val_r <= nxt_val_s;
                    best_idx_r <= nxt_idx_s;
                    // The counter parks on the last lane rather than stepping past it.
                    if (last_s) begin
                        o_idx        <= nxt_idx_s;
                        o_max        <= nxt_val_s;
                        o_post_valid <= 1'b1;
                        state_r      <= DONE;
                    end else begin
                        cnt_r <= cnt_r + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (post_fire_s) begin
                        o_post_valid <= 1'b0;
                        o_pre_ready  <= 1'b1;
                        cnt_r        <= {IDX_W{1'b0}};
                        state_r      <= IDLE;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    o_pre_ready  <= 1'b1;
                    o_post_valid <= 1'b0;
                    cnt_r        <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_res_argmax.sv
// Self-checking bench for res_argmax: vector table plus hand sequences, results checked via a scoreboard queue.
module tb_res_argmax;

    localparam int N_CLS  = 10;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 4;

    typedef logic [DATA_W-1:0] vec_t [N_CLS];

    typedef struct {
        vec_t             lanes;
        logic [IDX_W-1:0] idx;
        logic [DATA_W-1:0] max;
    } vec_rec_t;

    typedef struct {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] max;
        int                acc;
    } exp_t;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_pre_valid = 1'b0;
    logic              o_pre_ready;
    logic [DATA_W-1:0] res [N_CLS-1:0];
    logic              o_post_valid;
    logic              i_post_ready = 1'b1;
    logic [IDX_W-1:0]  o_idx;
    logic [DATA_W-1:0] o_max;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic prev_valid = 1'b0;
    exp_t q[$];

    res_argmax #(.N_CLS(N_CLS), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_pre_valid  (i_pre_valid),
        .o_pre_ready  (o_pre_ready),
        .i_res        (res),
        .o_post_valid (o_post_valid),
        .i_post_ready (i_post_ready),
        .o_idx        (o_idx),
        .o_max        (o_max)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference argmax: first occurrence of the largest value.
    function automatic exp_t ref_max(input vec_t v);
        exp_t r;
        r.idx = '0;
        r.max = v[0];
        r.acc = 0;
        for (int i = 1; i < N_CLS; i++) begin
`ifdef ARGMAX_SIGNED_EN
            if ($signed(v[i]) > $signed(r.max)) begin
`else
            if (v[i] > r.max) begin
`endif
                r.max = v[i];
                r.idx = IDX_W'(i);
            end
        end
        return r;
    endfunction

    // Scoreboard: checks latency on the rising edge of valid and pops/compares on each post_fire.
    always @(negedge i_clk) begin
        exp_t e;
        if (!i_rst) begin
            if (o_post_valid && !prev_valid) begin
                if (q.size() == 0) chk("spurious_valid", 64'(o_post_valid), 64'd0);
                else chk("latency", 64'(cyc - q[0].acc), 64'(N_CLS - 1));
            end
            if (o_post_valid && i_post_ready && q.size() > 0) begin
                e = q.pop_front();
                chk("idx", 64'(o_idx), 64'(e.idx));
                chk("max", 64'(o_max), 64'(e.max));
            end
        end
        prev_valid = o_post_valid;
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input vec_t v, input logic [IDX_W-1:0] ei, input logic [DATA_W-1:0] em);
        int t = 0;
        exp_t e;
        while (!o_pre_ready && t < 100) begin
            step();
            t++;
        end
        chk("pre_ready_wait", 64'(o_pre_ready), 64'd1);
        for (int i = 0; i < N_CLS; i++) res[i] = v[i];
        i_pre_valid = 1'b1;
        step();
        e.idx = ei;
        e.max = em;
        e.acc = cyc;
        q.push_back(e);
        i_pre_valid = 1'b0;
        for (int i = 0; i < N_CLS; i++) res[i] = $urandom;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() > 0 && t < 200) begin
            step();
            t++;
        end
        chk("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    initial begin
        vec_rec_t tbl[6];
        vec_t     v;
        exp_t     r;
        logic [IDX_W-1:0]  hold_idx;
        logic [DATA_W-1:0] hold_max;
        logic              stable;
        int                k;
        int                last_acc;
        int                seen;

        tbl[0].lanes = '{32'd5, 32'd3, 32'd9, 32'd1, 32'd0, 32'd2, 32'd8, 32'd7, 32'd4, 32'd6};
        tbl[0].idx = 4'd2;  tbl[0].max = 32'd9;
        tbl[1].lanes = '{default: 32'h0000_0010};
        tbl[1].idx = 4'd0;  tbl[1].max = 32'h0000_0010;
        tbl[2].lanes = '{32'd1, 32'd1, 32'd1, 32'd100, 32'd1, 32'd1, 32'd1, 32'd100, 32'd1, 32'd1};
        tbl[2].idx = 4'd3;  tbl[2].max = 32'd100;
        tbl[3].lanes = '{32'hFFFF_FFFF, 32'h0000_0001, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
`ifdef ARGMAX_SIGNED_EN
        tbl[3].idx = 4'd1;  tbl[3].max = 32'h0000_0001;
`else
        tbl[3].idx = 4'd0;  tbl[3].max = 32'hFFFF_FFFF;
`endif
        tbl[4].lanes = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd42};
        tbl[4].idx = 4'd9;  tbl[4].max = 32'd42;
        tbl[5].lanes = '{32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd7, 32'd7};
        tbl[5].idx = 4'd0;  tbl[5].max = 32'd7;

        for (int i = 0; i < N_CLS; i++) res[i] = '0;

        // Reset state
        i_rst = 1'b1;
        step(); step(); step();
        chk("rst_post_valid", 64'(o_post_valid), 64'd0);
        chk("rst_idx", 64'(o_idx), 64'd0);
        chk("rst_max", 64'(o_max), 64'd0);
        i_rst = 1'b0;
        step();
        chk("rst_pre_ready", 64'(o_pre_ready), 64'd1);

        // Table vectors, one at a time; after each result the block must be ready again
        for (int t = 0; t < 6; t++) begin
            send(tbl[t].lanes, tbl[t].idx, tbl[t].max);
            drain();
            chk("idle_after_fire", 64'({o_pre_ready, o_post_valid}), 64'b10);
        end

        // Backpressure: result held for 20 cycles
        i_post_ready = 1'b0;
        send(tbl[0].lanes, tbl[0].idx, tbl[0].max);
        k = 0;
        while (!o_post_valid && k < 50) begin
            step();
            k++;
        end
        chk("bp_valid", 64'(o_post_valid), 64'd1);
        hold_idx = o_idx;
        hold_max = o_max;
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (!o_post_valid || o_pre_ready || o_idx !== hold_idx || o_max !== hold_max) stable = 1'b0;
        end
        chk("bp_stable", 64'(stable), 64'd1);
        i_post_ready = 1'b1;
        step();
        chk("bp_single_fire", 64'(q.size()), 64'd0);
        chk("bp_ready_after", 64'({o_pre_ready, o_post_valid}), 64'b10);

        // Reset mid-scan discards the result
        send(tbl[2].lanes, tbl[2].idx, tbl[2].max);
        step(); step(); step();
        i_rst = 1'b1;
        q.delete();
        step();
        i_rst = 1'b0;
        chk("abort_valid", 64'(o_post_valid), 64'd0);
        chk("abort_pre_ready", 64'(o_pre_ready), 64'd1);
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (o_post_valid) seen++;
        end
        chk("abort_no_result", 64'(seen), 64'd0);
        send(tbl[0].lanes, tbl[0].idx, tbl[0].max);
        drain();

        // Back-to-back random vectors with pre_valid held high
        k = 0;
        last_acc = -1;
        for (int i = 0; i < N_CLS; i++) v[i] = $urandom;
        i_pre_valid = 1'b1;
        for (int c = 0; c < 200 && k < 5; c++) begin
            for (int i = 0; i < N_CLS; i++) res[i] = v[i];
            if (o_pre_ready) begin
                step();
                r = ref_max(v);
                r.acc = cyc;
                q.push_back(r);
                if (last_acc >= 0) chk("b2b_spacing", 64'(cyc - last_acc), 64'(N_CLS + 1));
                last_acc = cyc;
                k++;
                for (int i = 0; i < N_CLS; i++) v[i] = $urandom_range(0, 15);
            end else begin
                step();
            end
        end
        i_pre_valid = 1'b0;
        chk("b2b_count", 64'(k), 64'd5);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
